// File: rtl/pipelined_adder_tree.sv
// Fully pipelined binary adder tree: an input register stage plus one register stage per tree level,
// followed by a running accumulator with a sticky overflow flag.
module pipelined_adder_tree #(
    parameter int ADDER_WIDTH = 24,
    parameter int NUM_INPUTS  = 8,
    parameter int SIGNED      = 0,
    parameter int ACC_EXTRA   = 8,
    localparam int LEVELS     = $clog2(NUM_INPUTS),
    localparam int SUM_W      = ADDER_WIDTH + LEVELS,
    localparam int ACC_W      = SUM_W + ACC_EXTRA
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_INPUTS*ADDER_WIDTH-1:0] in_data,
    input  logic                              in_valid,
    input  logic                              in_clr,
    output logic [SUM_W-1:0]                  out_sum,
    output logic                              out_valid,
    output logic [ACC_W-1:0]                  acc_sum,
    output logic                              acc_valid,
    output logic                              acc_ovf
);

    logic [LEVELS:0] valid_d, valid_q;
    logic [LEVELS:0] clr_d, clr_q;

    // Level k holds NUM_INPUTS>>k partial sums, each one bit wider than the level below.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int LW = ADDER_WIDTH + k;
        localparam int LN = NUM_INPUTS >> k;

        logic [LW-1:0] sum_d [LN];
        logic [LW-1:0] sum_q [LN];

        if (k == 0) begin : g_in
            always_comb begin
                for (int i = 0; i < LN; i++) begin
                    sum_d[i] = in_data[i*ADDER_WIDTH +: ADDER_WIDTH];
                end
            end
        end else begin : g_add
            always_comb begin
                for (int j = 0; j < LN; j++) begin
                    sum_d[j] = {(SIGNED != 0) & g_lvl[k-1].sum_q[2*j][LW-2],   g_lvl[k-1].sum_q[2*j]}
                             + {(SIGNED != 0) & g_lvl[k-1].sum_q[2*j+1][LW-2], g_lvl[k-1].sum_q[2*j+1]};
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LN; i++) begin
                    sum_q[i] <= '0;
                end
            end else begin
                sum_q <= sum_d;
            end
        end
    end

    always_comb begin
        valid_d = {valid_q[LEVELS-1:0], in_valid};
        clr_d   = {clr_q[LEVELS-1:0], in_clr & in_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            clr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            clr_q   <= clr_d;
        end
    end

    logic [SUM_W-1:0] tree_sum;
    logic             tree_sign;
    logic [ACC_W-1:0] acc_ext;
    logic [ACC_W-1:0] acc_add;
    logic             acc_carry;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_sum_d, acc_sum_q;
    logic             acc_valid_d, acc_valid_q;
    logic             acc_ovf_d, acc_ovf_q;

    assign tree_sum  = g_lvl[LEVELS].sum_q[0];
    assign tree_sign = (SIGNED != 0) && tree_sum[SUM_W-1];

    // Overflow is carry-out for unsigned data, same-sign operands giving a flipped sign for signed data.
    always_comb begin
        acc_ext              = {ACC_W{tree_sign}};
        acc_ext[SUM_W-1:0]   = tree_sum;
        {acc_carry, acc_add} = {1'b0, acc_sum_q} + {1'b0, acc_ext};
        if (SIGNED != 0) begin
            add_ovf = (acc_sum_q[ACC_W-1] == acc_ext[ACC_W-1]) && (acc_add[ACC_W-1] != acc_sum_q[ACC_W-1]);
        end else begin
            add_ovf = acc_carry;
        end
    end

    always_comb begin
        acc_sum_d   = acc_sum_q;
        acc_ovf_d   = acc_ovf_q;
        acc_valid_d = valid_q[LEVELS];
        if (valid_q[LEVELS]) begin
            if (clr_q[LEVELS]) begin
                acc_sum_d = acc_ext;
                acc_ovf_d = 1'b0;
            end else begin
                acc_sum_d = acc_add;
                acc_ovf_d = acc_ovf_q | add_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_q   <= '0;
            acc_valid_q <= 1'b0;
            acc_ovf_q   <= 1'b0;
        end else begin
            acc_sum_q   <= acc_sum_d;
            acc_valid_q <= acc_valid_d;
            acc_ovf_q   <= acc_ovf_d;
        end
    end

    assign out_sum   = tree_sum;
    assign out_valid = valid_q[LEVELS];
    assign acc_sum   = acc_sum_q;
    assign acc_valid = acc_valid_q;
    assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: three configurations (unsigned 8x24, signed 4x8,
// unsigned 2x4 with no accumulator headroom) are checked against a plain-arithmetic reference model.
module tb_pipelined_adder_tree;

    typedef struct {
        longint sum;
        bit     clr;
        int     cyc;
    } item_t;

    typedef struct {
        longint acc;
        bit     ovf;
    } acc_item_t;

    logic   clk;
    logic   rst_n;
    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;
    longint ops [3][64];
    logic   vld [3];
    logic   clr_in [3];

    function automatic int cfg_w(int g);
        return (g == 0) ? 24 : (g == 1) ? 8 : 4;
    endfunction

    function automatic int cfg_n(int g);
        return (g == 0) ? 8 : (g == 1) ? 4 : 2;
    endfunction

    function automatic int cfg_s(int g);
        return (g == 1) ? 1 : 0;
    endfunction

    function automatic int cfg_e(int g);
        return (g == 0) ? 8 : (g == 1) ? 4 : 0;
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference accumulator: exact integer sum, then range test and wrap to aw bits.
    function automatic void acc_step(input int aw, input bit sgn, input bit clr, input longint s,
                                     inout longint acc, inout bit ovf);
        longint full;
        longint t;
        full = longint'(1) << aw;
        if (clr) begin
            acc = s;
            ovf = 1'b0;
        end else begin
            t = acc + s;
            if (sgn) begin
                if (t >= full / 2 || t < -(full / 2)) ovf = 1'b1;
            end else begin
                if (t >= full) ovf = 1'b1;
            end
            t = t & (full - 1);
            if (sgn && t >= full / 2) t = t - full;
            acc = t;
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W  = cfg_w(g);
        localparam int N  = cfg_n(g);
        localparam int S  = cfg_s(g);
        localparam int E  = cfg_e(g);
        localparam int L  = $clog2(N);
        localparam int SW = W + L;
        localparam int AW = SW + E;
        localparam longint SMASK = (longint'(1) << SW) - 1;
        localparam longint AMASK = (longint'(1) << AW) - 1;

        logic [N*W-1:0] data;
        logic [SW-1:0]  out_sum;
        logic           out_valid;
        logic [AW-1:0]  acc_sum;
        logic           acc_valid;
        logic           acc_ovf;

        item_t     q_out [$];
        acc_item_t q_acc [$];
        item_t     it;
        acc_item_t ai;
        longint    s;
        longint    acc_m = 0;
        bit        ovf_m = 1'b0;
        longint    acc_commit = 0;

        always_comb begin
            data = '0;
            for (int i = 0; i < N; i++) data[i*W +: W] = W'(ops[g][i]);
        end

        pipelined_adder_tree #(
            .ADDER_WIDTH (W),
            .NUM_INPUTS  (N),
            .SIGNED      (S),
            .ACC_EXTRA   (E)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (data),
            .in_valid  (vld[g]),
            .in_clr    (clr_in[g]),
            .out_sum   (out_sum),
            .out_valid (out_valid),
            .acc_sum   (acc_sum),
            .acc_valid (acc_valid),
            .acc_ovf   (acc_ovf)
        );

        always @(posedge clk) begin
            if (rst_n && vld[g]) begin
                s = 0;
                for (int i = 0; i < N; i++) s = s + ops[g][i];
                q_out.push_back('{sum: s, clr: clr_in[g], cyc: cyc});
            end
        end

        always @(negedge rst_n) begin
            q_out.delete();
            q_acc.delete();
            acc_m      = 0;
            ovf_m      = 1'b0;
            acc_commit = 0;
        end

        always @(negedge clk) begin
            if (rst_n) begin
                if (acc_valid) begin
                    if (q_acc.size() == 0) begin
                        checkOutput($sformatf("c%0d_acc_valid_unexpected", g), acc_valid, 0);
                    end else begin
                        ai = q_acc.pop_front();
                        checkOutput($sformatf("c%0d_acc_sum", g), acc_sum, ai.acc & AMASK);
                        checkOutput($sformatf("c%0d_acc_ovf", g), acc_ovf, ai.ovf);
                        acc_commit = ai.acc;
                    end
                end else begin
                    if (q_acc.size() != 0) begin
                        checkOutput($sformatf("c%0d_acc_valid_missing", g), acc_valid, 1);
                        q_acc.delete(0);
                    end
                    checkOutput($sformatf("c%0d_acc_hold", g), acc_sum, acc_commit & AMASK);
                end
                if (out_valid) begin
                    if (q_out.size() == 0) begin
                        checkOutput($sformatf("c%0d_out_valid_unexpected", g), out_valid, 0);
                    end else begin
                        it = q_out.pop_front();
                        checkOutput($sformatf("c%0d_out_sum", g), out_sum, it.sum & SMASK);
                        checkOutput($sformatf("c%0d_latency", g), cyc, it.cyc + L + 1);
                        acc_step(AW, S != 0, it.clr, it.sum, acc_m, ovf_m);
                        q_acc.push_back('{acc: acc_m, ovf: ovf_m});
                    end
                end else if (q_out.size() != 0 && cyc > q_out[0].cyc + L + 1) begin
                    checkOutput($sformatf("c%0d_out_valid_missing", g), out_valid, 1);
                    q_out.delete(0);
                end
            end
        end
    end

    task automatic applyStimulus(input int g, input bit c);
        vld[g]    = 1'b1;
        clr_in[g] = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            vld[g]    = 1'b0;
            clr_in[g] = 1'b0;
        end
    endtask

    task automatic set_all(input int g, input longint v);
        for (int i = 0; i < 64; i++) ops[g][i] = v;
    endtask

    task automatic rand_vec(input int g);
        longint r;
        for (int i = 0; i < 64; i++) begin
            r = longint'($urandom_range(0, (1 << cfg_w(g)) - 1));
            if (cfg_s(g) != 0 && r >= (longint'(1) << (cfg_w(g) - 1))) r = r - (longint'(1) << cfg_w(g));
            ops[g][i] = (i < cfg_n(g)) ? r : 0;
        end
    endtask

    task automatic check_zeros(input string tag);
        checkOutput({tag, "_c0_out_sum"}, cfg[0].out_sum, 0);
        checkOutput({tag, "_c0_acc_sum"}, cfg[0].acc_sum, 0);
        checkOutput({tag, "_c0_flags"}, {cfg[0].out_valid, cfg[0].acc_valid, cfg[0].acc_ovf}, 0);
        checkOutput({tag, "_c1_out_sum"}, cfg[1].out_sum, 0);
        checkOutput({tag, "_c1_acc_sum"}, cfg[1].acc_sum, 0);
        checkOutput({tag, "_c1_flags"}, {cfg[1].out_valid, cfg[1].acc_valid, cfg[1].acc_ovf}, 0);
        checkOutput({tag, "_c2_out_sum"}, cfg[2].out_sum, 0);
        checkOutput({tag, "_c2_acc_sum"}, cfg[2].acc_sum, 0);
        checkOutput({tag, "_c2_flags"}, {cfg[2].out_valid, cfg[2].acc_valid, cfg[2].acc_ovf}, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b1;
        for (int g = 0; g < 3; g++) begin
            vld[g]    = 1'b0;
            clr_in[g] = 1'b0;
            set_all(g, 0);
        end
        #1 rst_n = 1'b0;
        #2 check_zeros("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) tick();
        check_zeros("idle");

        for (int i = 0; i < 8; i++) ops[0][i] = i + 1;
        applyStimulus(0, 1'b1);
        tick();
        repeat (6) tick();
        set_all(0, 64'hFFFFFF);
        applyStimulus(0, 1'b1);
        tick();
        set_all(0, 0);
        applyStimulus(0, 1'b0);
        tick();

        set_all(1, -128);
        applyStimulus(1, 1'b1);
        tick();
        ops[1][0] = 127;
        ops[1][1] = -1;
        ops[1][2] = 5;
        ops[1][3] = -3;
        applyStimulus(1, 1'b0);
        tick();
        repeat (6) tick();

        for (int k = 0; k < 5; k++) begin
            set_all(0, 1);
            applyStimulus(0, k == 0);
            tick();
        end
        set_all(0, 2);
        applyStimulus(0, 1'b1);
        tick();

        set_all(2, 15);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2, k == 0);
            tick();
        end
        repeat (8) tick();

        repeat (300) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(3) != 0) begin
                    rand_vec(g);
                    applyStimulus(g, $urandom_range(7) == 0);
                end
            end
            tick();
        end
        repeat (8) tick();

        for (int k = 0; k < 2; k++) begin
            for (int g = 0; g < 3; g++) begin
                rand_vec(g);
                applyStimulus(g, 1'b0);
            end
            tick();
        end
        rst_n = 1'b0;
        #1 check_zeros("rst_inflight");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) ops[0][i] = 3 * i;
        applyStimulus(0, 1'b0);
        tick();
        repeat (10) tick();

        checkOutput("c0_pending_out", cfg[0].q_out.size(), 0);
        checkOutput("c0_pending_acc", cfg[0].q_acc.size(), 0);
        checkOutput("c1_pending_out", cfg[1].q_out.size(), 0);
        checkOutput("c1_pending_acc", cfg[1].q_acc.size(), 0);
        checkOutput("c2_pending_out", cfg[2].q_out.size(), 0);
        checkOutput("c2_pending_acc", cfg[2].q_acc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
